// File: rtl/score_frame_rx.sv
// Receive-side decoder for the inter-board score link: hunts for SYNC, assembles a
// 6-digit BCD score, validates digits and XOR checksum, and tracks link health.
module score_frame_rx #(
    parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
    parameter int unsigned TIMEOUT_CYCLES = 750000,
    parameter int unsigned LINK_ERR_LIMIT = 3
) (
    input  logic        pclk,
    input  logic        rst,
    input  logic        rx_done_tick,
    input  logic [7:0]  rx_data,
    output logic [23:0] ext_data,
    output logic        frame_valid,
    output logic        frame_err,
    output logic [7:0]  err_count,
    output logic        link_up
);
    localparam int unsigned TW       = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [7:0]  CONS_LIM = 8'(LINK_ERR_LIMIT);

    typedef enum logic [2:0] {IDLE, BYTE2, BYTE1, BYTE0, CHECK} state_t;

    state_t        state_q, state_d;
    logic [23:0]   shadow_q, shadow_d;
    logic [7:0]    acc_q, acc_d;
    logic          bcd_bad_q, bcd_bad_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic [23:0]   ext_q, ext_d;
    logic          fv_q, fv_d;
    logic          fe_q, fe_d;
    logic [7:0]    errc_q, errc_d;
    logic [7:0]    cons_q, cons_d;
    logic          link_q, link_d;
    logic          accept, reject;
    logic          nib_bad;

    assign nib_bad = (rx_data[7:4] > 4'd9) || (rx_data[3:0] > 4'd9);

    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            shadow_q  <= '0;
            acc_q     <= '0;
            bcd_bad_q <= 1'b0;
            tmo_q     <= '0;
            ext_q     <= '0;
            fv_q      <= 1'b0;
            fe_q      <= 1'b0;
            errc_q    <= '0;
            cons_q    <= '0;
            link_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            shadow_q  <= shadow_d;
            acc_q     <= acc_d;
            bcd_bad_q <= bcd_bad_d;
            tmo_q     <= tmo_d;
            ext_q     <= ext_d;
            fv_q      <= fv_d;
            fe_q      <= fe_d;
            errc_q    <= errc_d;
            cons_q    <= cons_d;
            link_q    <= link_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        shadow_d  = shadow_q;
        acc_d     = acc_q;
        bcd_bad_d = bcd_bad_q;
        tmo_d     = tmo_q;
        ext_d     = ext_q;
        fv_d      = 1'b0;
        fe_d      = 1'b0;
        errc_d    = errc_q;
        cons_d    = cons_q;
        link_d    = link_q;
        accept    = 1'b0;
        reject    = 1'b0;

        case (state_q)
            IDLE: begin
                if (rx_done_tick && rx_data == SYNC_BYTE) begin
                    state_d   = BYTE2;
                    acc_d     = '0;
                    bcd_bad_d = 1'b0;
                end
            end
            BYTE2, BYTE1, BYTE0: begin
                if (rx_done_tick) begin
                    acc_d     = acc_q ^ rx_data;
                    bcd_bad_d = bcd_bad_q | nib_bad;
                    case (state_q)
                        BYTE2:   begin shadow_d[23:16] = rx_data; state_d = BYTE1; end
                        BYTE1:   begin shadow_d[15:8]  = rx_data; state_d = BYTE0; end
                        default: begin shadow_d[7:0]   = rx_data; state_d = CHECK; end
                    endcase
                end
            end
            CHECK: begin
                if (rx_done_tick) begin
                    if (rx_data == acc_q && !bcd_bad_q) accept = 1'b1;
                    else                                reject = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // A tick arriving on the expiry cycle is processed; the timeout only fires on silence.
        if (state_q == IDLE) begin
            tmo_d = '0;
        end else if (rx_done_tick) begin
            tmo_d = '0;
        end else if (tmo_q == TMO_LAST) begin
            tmo_d   = '0;
            state_d = IDLE;
            reject  = 1'b1;
        end else begin
            tmo_d = tmo_q + 1'b1;
        end

        if (accept) begin
            ext_d  = shadow_q;
            fv_d   = 1'b1;
            link_d = 1'b1;
            cons_d = '0;
        end
        if (reject) begin
            fe_d = 1'b1;
            if (errc_q != 8'hFF) errc_d = errc_q + 8'd1;
            if (cons_q != 8'hFF) cons_d = cons_q + 8'd1;
            if (cons_d >= CONS_LIM) link_d = 1'b0;
        end
    end

    assign ext_data    = ext_q;
    assign frame_valid = fv_q;
    assign frame_err   = fe_q;
    assign err_count   = errc_q;
    assign link_up     = link_q;
endmodule
